bitpack_z: RTL and testbench
============================

BITPACK_Z -- requirements
Module: bitpack_z

Interface
REQ-001 Parameter L, default 7: number of polynomials in vector z.
REQ-002 Parameter N, default 256: coefficients per polynomial.
REQ-003 Parameter GAMMA1, default 19: gamma1 = 2^GAMMA1; packed width C = GAMMA1+1 = 20.
REQ-004 Parameter COEFF_WIDTH, default 24: stored coefficient width; WORD_LEN = 4*COEFF_WIDTH = 96.
REQ-005 Parameter DATA_OUT_BITS, default 64: output stream word width.
REQ-006 clk  in  1  clock; all logic on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 start  in  1  one-cycle pulse in IDLE that begins packing; ignored while busy.
REQ-009 addr_z  out  9  BRAM read address; word k holds coeffs 4k..4k+3, polynomial r at 64r..64r+63.
REQ-010 dout_z  in  96  BRAM read data; coeff j at bits [24j +: 24]; one-cycle read latency.
REQ-011 data_out  out  64  packed stream word.
REQ-012 out_valid  out  1  data_out is valid.
REQ-013 out_ready  in  1  sink accepts data_out when out_valid and out_ready are both high.
REQ-014 out_last  out  1  high with the final (560th) word.
REQ-015 done  out  1  one-cycle pulse after the final word is accepted.
REQ-016 err  out  1  sticky range-error flag (see Configuration).

Function
REQ-017 Coefficient c in [0,q), q = 8380417, maps to v = gamma1 - c when c <= gamma1, else v = gamma1 - c + q; truncate to 20 bits.
REQ-018 Packing is little-endian by bit: coefficient i occupies stream bits [20i +: 20]; stream bit b is data_out bit b mod 64 of word b/64.
REQ-019 Total output is L*N*20/64 = 560 words, with no padding and no partial last word.
REQ-020 FSM states: IDLE, FETCH (drive addr, wait 1 cycle), LOAD (capture 4 coeffs), PACK (shift coeffs into buffer), EMIT (present word), FINISH (pulse done, go IDLE).
REQ-021 The accumulator buffer is at least 84 bits; the block emits a word whenever the buffer holds 64 or more bits; the remainder shifts down.
REQ-022 While out_valid=1 and out_ready=0, data_out, out_last and out_valid are held stable; no BRAM address advances past what the buffer can absorb.
REQ-023 Sustained throughput is at least one output word per 4 cycles with out_ready tied high.
REQ-024 addr_z runs 0..447 monotonically, and each address is read exactly once per run.
REQ-025 A start received while not in IDLE is ignored; a start in the same cycle as done is ignored.

Reset
REQ-026 On rst, state=IDLE; addr_z=0, data_out=0, out_valid=0, out_last=0, done=0, err=0; buffer and all counters cleared.
REQ-027 rst asserted mid-run aborts immediately; the next start restarts from address 0 with no residual buffer bits.
REQ-028 err clears only on rst or on an accepted start.

Configuration
REQ-029 Macro BITPACK_Z_RANGE_CHECK_EN defined: err sets when any c satisfies gamma1 < c < q-gamma1+1; packing continues with the truncated value.
REQ-030 Macro undefined: err is tied 0 and no comparator logic is synthesized.

Structure
REQ-031 Q, GAMMA1, C, COEFF_WIDTH, WORD_LEN and the FSM state enum belong in the shared dilithium parameter package.
REQ-032 Sub-module coeff_to_packed (combinational, 24-bit in, 20-bit out, optional range flag) implements REQ-017/029; it is instantiated 4 times or once time-multiplexed.

Verification
REQ-033 All coeffs 0, out_ready=1 -> 560 words; word 0 = 0x0800008000080000; out_last only on word 559; done one cycle after.
REQ-034 All coeffs 524288 (gamma1) -> every word 0x0000000000000000.
REQ-035 All coeffs 7856130 (q-gamma1+1) -> every word 0xFFFFFFFFFFFFFFFF; err=0.
REQ-036 Coeff i = i mod q ramp, out_ready toggled randomly with 5-cycle low stretches -> stream matches the golden BitPack model, and data_out stays stable while stalled.
REQ-037 Macro defined, coeff 200 of polynomial 3 = 1000000 -> err rises and stays 1 until the next start; macro undefined -> err=0.
REQ-038 rst pulsed after word 100, then start -> full correct 560-word stream from address 0.

Source files
------------

// File: rtl/bitpack_z_pkg.sv
// Shared dilithium parameters for the z-vector bit packer: modulus, gamma1
// exponent, packed coefficient width, BRAM word geometry and FSM state codes.
package bitpack_z_pkg;

  localparam int Q           = 8380417;
  localparam int GAMMA1      = 19;            // gamma1 = 2^GAMMA1
  localparam int C           = GAMMA1 + 1;    // packed bits per coefficient
  localparam int COEFF_WIDTH = 24;
  localparam int WORD_LEN    = 4 * COEFF_WIDTH;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_LOAD   = 3'd2;
  localparam state_t S_PACK   = 3'd3;
  localparam state_t S_EMIT   = 3'd4;
  localparam state_t S_FINISH = 3'd5;

endpackage

// File: rtl/bitpack_z_coeff_to_packed.sv
// coeff_to_packed: maps one stored coefficient c in [0,q) to the packed
// value gamma1 - c (mod q), truncated to GAMMA1+1 bits.
// Optional macro BITPACK_Z_RANGE_CHECK_EN adds a flag for coefficients that
// fall outside the legal z range (gamma1 < c < q-gamma1+1).
module coeff_to_packed #(
  parameter int GAMMA1      = 19,
  parameter int COEFF_WIDTH = 24
) (
  input  logic [COEFF_WIDTH-1:0] i_coeff,
  output logic [GAMMA1:0]        o_packed,
  output logic                   o_range_err
);
  import bitpack_z_pkg::*;

  localparam logic [COEFF_WIDTH:0] G1_V  = (COEFF_WIDTH+1)'(64'd1 << GAMMA1);
  localparam logic [COEFF_WIDTH:0] Q_V   = (COEFF_WIDTH+1)'(Q);
  localparam logic [COEFF_WIDTH:0] ONE_V = (COEFF_WIDTH+1)'(1);

  logic [COEFF_WIDTH:0] w_c;

  assign w_c = {1'b0, i_coeff};

  // Centred mapping; the +q branch keeps the intermediate non-negative.
  always_comb begin
    o_packed = '0;
    if (w_c <= G1_V) begin
      o_packed = (GAMMA1+1)'(G1_V - w_c);
    end else begin
      o_packed = (GAMMA1+1)'(G1_V + Q_V - w_c);
    end
  end

`ifdef BITPACK_Z_RANGE_CHECK_EN
  // Flag values that do not belong to a valid z polynomial.
  always_comb begin
    o_range_err = (w_c > G1_V) && (w_c < (Q_V - G1_V + ONE_V));
  end
`else
  assign o_range_err = 1'b0;
`endif

endmodule

// File: rtl/bitpack_z.sv
// bitpack_z: streams the BitPack encoding of vector z (L polynomials of N
// coefficients, GAMMA1+1 bits each) as DATA_OUT_BITS-wide words with a
// valid/ready handshake. One BRAM word (4 coefficients) is fetched only when
// the accumulator holds fewer than one output word, so reads never run ahead.
// Optional macro BITPACK_Z_RANGE_CHECK_EN enables the sticky range-error flag;
// without it err is constant 0.
module bitpack_z #(
  parameter int L             = 7,
  parameter int N             = 256,
  parameter int GAMMA1        = 19,
  parameter int COEFF_WIDTH   = 24,
  parameter int DATA_OUT_BITS = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  output logic [8:0]                 o_addr_z,
  input  logic [4*COEFF_WIDTH-1:0]   i_dout_z,
  output logic [DATA_OUT_BITS-1:0]   o_data_out,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic                       o_out_last,
  output logic                       o_done,
  output logic                       o_err
);
  import bitpack_z_pkg::*;

  localparam int PACK_W  = GAMMA1 + 1;
  localparam int WORD_W  = 4 * COEFF_WIDTH;
  localparam int GROUP_W = 4 * PACK_W;
  // Buffer never holds a full output word before a group is appended.
  localparam int BUF_W   = DATA_OUT_BITS + GROUP_W;
  localparam int CNT_W   = $clog2(BUF_W + 1);
  localparam int NUM_OUT = (L * N * PACK_W) / DATA_OUT_BITS;
  localparam int WCNT_W  = $clog2(NUM_OUT + 1);

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_OUT - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [CNT_W-1:0]  GROUP_BITS = CNT_W'(GROUP_W);
  localparam logic [CNT_W-1:0]  OUT_BITS   = CNT_W'(DATA_OUT_BITS);

  state_t                    r_state;
  logic [8:0]                r_addr;
  logic [WORD_W-1:0]         r_coeffs;
  logic [BUF_W-1:0]          r_buf;
  logic [CNT_W-1:0]          r_cnt;
  logic [WCNT_W-1:0]         r_word_cnt;
  logic [DATA_OUT_BITS-1:0]  r_data_out;
  logic                      r_out_valid;
  logic                      r_out_last;
  logic                      r_done;
  logic                      r_err;

  logic [GROUP_W-1:0]        w_group;
  logic [3:0]                w_range;
  logic [BUF_W-1:0]          w_buf_packed;
  logic [CNT_W-1:0]          w_cnt_packed;
  logic [BUF_W-1:0]          w_buf_shift;
  logic [CNT_W-1:0]          w_cnt_shift;
  logic                      w_accept;
  logic                      w_is_last;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_c2p
      coeff_to_packed #(
        .GAMMA1      (GAMMA1),
        .COEFF_WIDTH (COEFF_WIDTH)
      ) u_c2p (
        .i_coeff     (r_coeffs[g*COEFF_WIDTH +: COEFF_WIDTH]),
        .o_packed    (w_group[g*PACK_W +: PACK_W]),
        .o_range_err (w_range[g])
      );
    end
  endgenerate

  // Next buffer contents for the append (PACK) and drain (EMIT) cases.
  always_comb begin
    w_buf_packed = r_buf | (BUF_W'(w_group) << r_cnt);
    w_cnt_packed = r_cnt + GROUP_BITS;
    w_buf_shift  = r_buf >> DATA_OUT_BITS;
    w_cnt_shift  = r_cnt - OUT_BITS;
    w_accept     = r_out_valid & i_out_ready;
    w_is_last    = (r_word_cnt == LAST_WORD);
  end

  // Packing FSM, accumulator, output register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= 9'd0;
      r_coeffs    <= '0;
      r_buf       <= '0;
      r_cnt       <= '0;
      r_word_cnt  <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_FETCH;
            r_addr     <= 9'd0;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_word_cnt <= '0;
            r_err      <= 1'b0;
          end
        end
        S_FETCH: begin
          // Address is already on the bus; BRAM answers next cycle.
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_coeffs <= i_dout_z;
          r_state  <= S_PACK;
        end
        S_PACK: begin
          r_buf <= w_buf_packed;
          r_cnt <= w_cnt_packed;
          r_err <= r_err | (|w_range);
          if (w_cnt_packed >= OUT_BITS) begin
            r_data_out  <= w_buf_packed[DATA_OUT_BITS-1:0];
            r_out_valid <= 1'b1;
            r_out_last  <= w_is_last;
            r_state     <= S_EMIT;
          end else begin
            r_addr  <= r_addr + 9'd1;
            r_state <= S_FETCH;
          end
        end
        S_EMIT: begin
          // Outputs hold while the sink stalls.
          if (w_accept) begin
            r_buf      <= w_buf_shift;
            r_cnt      <= w_cnt_shift;
            r_word_cnt <= r_word_cnt + WCNT_ONE;
            if (w_is_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_FINISH;
            end else if (w_cnt_shift >= OUT_BITS) begin
              r_data_out <= w_buf_shift[DATA_OUT_BITS-1:0];
              r_out_last <= ((r_word_cnt + WCNT_ONE) == LAST_WORD);
            end else begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_addr      <= r_addr + 9'd1;
              r_state     <= S_FETCH;
            end
          end
        end
        S_FINISH: begin
          // done is high during this cycle; a start here is not honoured.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_addr_z    = r_addr;
  assign o_data_out  = r_data_out;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_bitpack_z.sv
// Self-checking bench for bitpack_z: table-driven uniform fills, ramp and
// random coefficients under random back-pressure, start/abort corner cases.
// Expected words come from a bit-level BitPack model built from the BRAM image.
module tb_bitpack_z;

  localparam int unsigned QM   = 8380417;
  localparam int unsigned G1   = 524288;
  localparam int          NC   = 7 * 256;
  localparam int          NOUT = 560;
`ifdef BITPACK_Z_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [8:0]  addr_z;
  logic [95:0] dout_z = '0;
  logic [63:0] data_out;
  logic        out_valid;
  logic        i_out_ready = 1'b0;
  logic        out_last;
  logic        done;
  logic        err;

  int unsigned mem [NC];
  logic [63:0] exp_w [NOUT];
  bit          sbits [NOUT*64];
  logic [63:0] first_word;
  int          errors = 0;
  int          checks = 0;

  bitpack_z dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .o_addr_z    (addr_z),
    .i_dout_z    (dout_z),
    .o_data_out  (data_out),
    .o_out_valid (out_valid),
    .i_out_ready (i_out_ready),
    .o_out_last  (out_last),
    .o_done      (done),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  // BRAM model, one-cycle read latency
  always @(posedge clk) begin
    int a;
    a = int'(addr_z);
    for (int j = 0; j < 4; j++)
      dout_z[24*j +: 24] <= (a < NC/4) ? 24'(mem[4*a + j]) : 24'd0;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, expv);
    end
  endtask

  function automatic int unsigned map_c(input int unsigned c);
    int unsigned v;
    v = (c <= G1) ? (G1 - c) : (G1 + QM - c);
    return v % (2 * G1);
  endfunction

  // Lay out every coefficient's 20 bits little-endian, then cut 64-bit words.
  task automatic build_expected();
    for (int i = 0; i < NC; i++) begin
      int unsigned v;
      v = map_c(mem[i]);
      for (int b = 0; b < 20; b++) sbits[20*i + b] = v[b];
    end
    for (int w = 0; w < NOUT; w++)
      for (int b = 0; b < 64; b++) exp_w[w][b] = sbits[64*w + b];
  endtask

  function automatic bit model_err();
    bit any;
    any = 1'b0;
    for (int i = 0; i < NC; i++)
      if (mem[i] > G1 && mem[i] < QM - G1 + 1) any = 1'b1;
    return RANGE_EN && any;
  endfunction

  // mode 0: ready high; mode 1: random ready with 5-cycle low stretches.
  // abort_after >= 0: return (at a negedge) once that many words were taken.
  task automatic run_stream(input int mode, input int abort_after, input bit busy_start,
                            input string tag);
    int words, cyc, mism, stall_bad, addr_bad, last_bad, done_cnt, low_left, prev_addr;
    bit prev_valid, prev_ready, prev_last, pend, done_ok, finished, rdy;
    logic [63:0] prev_data;
    words = 0; cyc = 0; mism = 0; stall_bad = 0; addr_bad = 0; last_bad = 0;
    done_cnt = 0; low_left = 0; prev_addr = 0;
    prev_valid = 0; prev_ready = 0; prev_last = 0; pend = 0; done_ok = 0; finished = 0;
    prev_data = '0;
    @(negedge clk); i_start = 1'b1; i_out_ready = 1'b0;
    @(negedge clk); i_start = 1'b0;
    chk({tag, "_addr_start"}, 64'(addr_z), 64'd0);
    chk({tag, "_err_clear_on_start"}, 64'(err), 64'd0);
    while (cyc < 20000 && !finished) begin
      if (done) done_cnt++;
      if (pend) begin
        done_ok = done;
        finished = 1'b1;
      end else begin
        if (prev_valid && !prev_ready)
          if (!out_valid || data_out !== prev_data || out_last !== prev_last) stall_bad++;
        if (int'(addr_z) != prev_addr && int'(addr_z) != prev_addr + 1) addr_bad++;
        prev_addr = int'(addr_z);
        i_start = (busy_start && cyc == 50);
        if (mode == 0) rdy = 1'b1;
        else if (low_left > 0) begin rdy = 1'b0; low_left--; end
        else if ($urandom_range(0, 7) == 0) begin rdy = 1'b0; low_left = 4; end
        else rdy = 1'($urandom_range(0, 1));
        i_out_ready = rdy;
        if (out_valid && (out_last !== (words == NOUT - 1))) last_bad++;
        if (!out_valid && out_last) last_bad++;
        if (out_valid && rdy) begin
          if (words == 0) first_word = data_out;
          if (words < NOUT && data_out !== exp_w[words]) begin
            if (mism == 0)
              $display("FAIL %s_word%0d: got=%h expected=%h", tag, words, data_out, exp_w[words]);
            mism++;
          end
          if (words == NOUT - 1) pend = 1'b1;
          words++;
        end
        prev_valid = out_valid; prev_ready = rdy; prev_data = data_out; prev_last = out_last;
        if (abort_after >= 0 && words == abort_after) return;
        @(negedge clk);
        cyc++;
      end
    end
    i_start = 1'b0;
    chk({tag, "_no_timeout"}, 64'(finished), 64'd1);
    chk({tag, "_word_count"}, 64'(words), 64'(NOUT));
    chk({tag, "_stream_mismatches"}, 64'(mism), 64'd0);
    chk({tag, "_stall_unstable"}, 64'(stall_bad), 64'd0);
    chk({tag, "_addr_jumps"}, 64'(addr_bad), 64'd0);
    chk({tag, "_addr_final"}, 64'(addr_z), 64'd447);
    chk({tag, "_last_misplaced"}, 64'(last_bad), 64'd0);
    chk({tag, "_done_after_last"}, 64'(done_ok), 64'd1);
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_err"}, 64'(err), 64'(model_err()));
    if (mode == 0) chk({tag, "_throughput_ok"}, 64'(cyc <= 4 * NOUT), 64'd1);
  endtask

  typedef struct {
    int unsigned fill;
    logic [63:0] w0;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{fill: 0,       w0: 64'h0800008000080000};
    tbl[1] = '{fill: G1,      w0: 64'h0000000000000000};
    tbl[2] = '{fill: 7856130, w0: 64'hFFFFFFFFFFFFFFFF};
    tbl[3] = '{fill: 1,       w0: 64'hF7FFFF7FFFF7FFFF};
    tbl[4] = '{fill: QM - 1,  w0: 64'h1800018000180001};
    for (int i = 0; i < NC; i++) mem[i] = 0;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_addr", 64'(addr_z), 64'd0);
    chk("rst_data", data_out, 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // uniform fills, ready high
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < NC; i++) mem[i] = tbl[t].fill;
      build_expected();
      run_stream(0, -1, 1'b0, $sformatf("fill%0d", t));
      chk($sformatf("fill%0d_word0", t), first_word, tbl[t].w0);
    end

    // start arriving in the done cycle is ignored
    i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_on_done_valid", 64'(out_valid), 64'd0);
    chk("start_on_done_addr", 64'(addr_z), 64'd447);

    // ramp with random stalls and a start pulse while busy
    for (int i = 0; i < NC; i++) mem[i] = i % QM;
    build_expected();
    run_stream(1, -1, 1'b1, "ramp");

    // random coefficients, random stalls
    for (int i = 0; i < NC; i++) mem[i] = $urandom % QM;
    build_expected();
    run_stream(1, -1, 1'b0, "rand");

    // out-of-range coefficient 200 of polynomial 3
    for (int i = 0; i < NC; i++) mem[i] = 0;
    mem[3*256 + 200] = 1000000;
    build_expected();
    run_stream(0, -1, 1'b0, "range");
    repeat (4) @(negedge clk);
    chk("range_err_sticky", 64'(err), 64'(RANGE_EN));
    mem[3*256 + 200] = 0;
    build_expected();
    run_stream(0, -1, 1'b0, "range_clear");

    // abort after word 100, then a clean restart
    for (int i = 0; i < NC; i++) mem[i] = (i * 7919) % QM;
    build_expected();
    run_stream(1, 100, 1'b0, "abort");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_out_ready = 1'b0;
    chk("abort_rst_valid", 64'(out_valid), 64'd0);
    chk("abort_rst_addr", 64'(addr_z), 64'd0);
    chk("abort_rst_data", data_out, 64'd0);
    @(negedge clk);
    run_stream(0, -1, 1'b0, "restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
